// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-enable divider, h/v counters, registered syncs and
// blanked 3-3-2 RGB, plus a one-cycle frame_start pulse at the (0,0) wrap.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [2:0] red_in,
  input  logic [2:0] green_in,
  input  logic [1:0] blue_in,
  output logic [9:0] xpos,
  output logic [9:0] ypos,
  output logic       video_on,
  output logic       pixel_tick,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] red,
  output logic [2:0] green,
  output logic [1:0] blue,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [9:0]       hcount_q, hcount_d;
  logic [9:0]       vcount_q, vcount_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic [7:0]       rgb_q, rgb_d;
  logic             frame_start_q, frame_start_d;
  logic             h_wrap, v_wrap;

  always_comb begin
    pixel_tick    = (div_cnt_q == DIV_LAST) && !Reset;
    video_on      = (hcount_q < H_ACT) && (vcount_q < V_ACT);
    h_wrap        = (hcount_q == H_LAST);
    v_wrap        = (vcount_q == V_LAST);

    div_cnt_d     = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    rgb_d         = rgb_q;
    frame_start_d = 1'b0;

    // Output stage samples the current counters, giving one pixel of latency to the pins.
    if (pixel_tick) begin
      hcount_d      = h_wrap ? '0 : hcount_q + 10'd1;
      if (h_wrap) begin
        vcount_d    = v_wrap ? '0 : vcount_q + 10'd1;
      end
      hsync_d       = !((hcount_q >= HS_FIRST) && (hcount_q <= HS_LAST));
      vsync_d       = !((vcount_q >= VS_FIRST) && (vcount_q <= VS_LAST));
      rgb_d         = video_on ? {red_in, green_in, blue_in} : '0;
      frame_start_d = h_wrap && v_wrap;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      div_cnt_q     <= '0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      rgb_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign xpos        = hcount_q;
  assign ypos        = vcount_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign red         = rgb_q[7:5];
  assign green       = rgb_q[4:2];
  assign blue        = rgb_q[1:0];
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 timing (line-level) plus a tiny raster
// (14x7, CLK_DIV=1) for frame-level vsync/frame_start behaviour.
module tb_vga_timing_gen;

  logic       clk;
  logic       rst_a, rst_b;
  logic [2:0] red_in, green_in;
  logic [1:0] blue_in;

  logic [9:0] xpos_a, ypos_a, xpos_b, ypos_b;
  logic       von_a, tick_a, hs_a, vs_a, fs_a;
  logic       von_b, tick_b, hs_b, vs_b, fs_b;
  logic [2:0] red_a, green_a, red_b, green_b;
  logic [1:0] blue_a, blue_b;

  int n_vec = 0;
  int n_bad = 0;
  int t     = 0;

  vga_timing_gen u_dut_a (
    .Clock(clk), .Reset(rst_a),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .xpos(xpos_a), .ypos(ypos_a), .video_on(von_a), .pixel_tick(tick_a),
    .hsync(hs_a), .vsync(vs_a), .red(red_a), .green(green_a), .blue(blue_a),
    .frame_start(fs_a)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_dut_b (
    .Clock(clk), .Reset(rst_b),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .xpos(xpos_b), .ypos(ypos_b), .video_on(von_b), .pixel_tick(tick_b),
    .hsync(hs_b), .vsync(vs_b), .red(red_b), .green(green_b), .blue(blue_b),
    .frame_start(fs_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s (t=%0d): got %0d expected %0d", tag, t, got, exp);
    end
  endtask

  // t counts rising edges since the last release; checks happen at the falling edge.
  task automatic to_t(input int target);
    while (t < target) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic a_early_checks();
    check_val("a_t0_tick", tick_a, 0);
    check_val("a_t0_x", xpos_a, 0);
    check_val("a_t0_hs", hs_a, 1);
    check_val("a_t0_vs", vs_a, 1);
    check_val("a_t0_red", red_a, 0);
    to_t(1);
    check_val("a_t1_tick", tick_a, 1);
    check_val("a_t1_x", xpos_a, 0);
    check_val("a_t1_red", red_a, 0);
    to_t(2);
    check_val("a_t2_tick", tick_a, 0);
    check_val("a_t2_x", xpos_a, 1);
    check_val("a_t2_red", red_a, 7);
    check_val("a_t2_green", green_a, 0);
    check_val("a_t2_blue", blue_a, 3);
    to_t(4);
    check_val("a_t4_x", xpos_a, 2);
  endtask

  initial begin
    rst_a    = 1'b1;
    rst_b    = 1'b1;
    red_in   = 3'd7;
    green_in = 3'd0;
    blue_in  = 2'd3;
    repeat (5) @(negedge clk);

    check_val("b_rst_tick", tick_b, 0);
    check_val("b_rst_x", xpos_b, 0);
    check_val("b_rst_hs", hs_b, 1);
    check_val("b_rst_vs", vs_b, 1);
    check_val("b_rst_red", red_b, 0);
    check_val("a_rst_hs", hs_a, 1);
    check_val("a_rst_vs", vs_a, 1);
    check_val("a_rst_blue", blue_a, 0);

    // Small raster: line 14 clocks, frame 98 clocks.
    rst_b = 1'b0;
    t = 0;
    #1;
    check_val("b_t0_tick", tick_b, 1);
    check_val("b_t0_x", xpos_b, 0);
    to_t(1);
    check_val("b_t1_x", xpos_b, 1);
    check_val("b_t1_red", red_b, 7);
    check_val("b_t1_blue", blue_b, 3);
    to_t(8);
    check_val("b_t8_red", red_b, 7);
    to_t(9);
    check_val("b_t9_red", red_b, 0);
    to_t(10);
    check_val("b_t10_hs", hs_b, 1);
    to_t(11);
    check_val("b_t11_hs", hs_b, 0);
    to_t(12);
    check_val("b_t12_hs", hs_b, 0);
    to_t(13);
    check_val("b_t13_hs", hs_b, 1);
    to_t(14);
    check_val("b_t14_x", xpos_b, 0);
    check_val("b_t14_y", ypos_b, 1);
    to_t(60);
    check_val("b_t60_von", von_b, 0);
    check_val("b_t60_red", red_b, 0);
    to_t(67);
    check_val("b_t67_hs_vblank", hs_b, 0);
    to_t(70);
    check_val("b_t70_y", ypos_b, 5);
    check_val("b_t70_vs", vs_b, 1);
    to_t(71);
    check_val("b_t71_vs", vs_b, 0);
    to_t(84);
    check_val("b_t84_vs", vs_b, 0);
    to_t(85);
    check_val("b_t85_vs", vs_b, 1);
    to_t(97);
    check_val("b_t97_fs", fs_b, 0);
    check_val("b_t97_x", xpos_b, 13);
    check_val("b_t97_y", ypos_b, 6);
    to_t(98);
    check_val("b_t98_fs", fs_b, 1);
    check_val("b_t98_x", xpos_b, 0);
    check_val("b_t98_y", ypos_b, 0);
    to_t(99);
    check_val("b_t99_fs", fs_b, 0);
    to_t(195);
    check_val("b_t195_fs", fs_b, 0);
    to_t(196);
    check_val("b_t196_fs", fs_b, 1);

    // Default 640x480 timing, CLK_DIV=2.
    check_val("a_rst_tick", tick_a, 0);
    rst_a = 1'b0;
    t = 0;
    #1;
    a_early_checks();
    to_t(1279);
    check_val("a_x639", xpos_a, 639);
    check_val("a_von639", von_a, 1);
    to_t(1280);
    check_val("a_von640", von_a, 0);
    check_val("a_red_t1280", red_a, 7);
    to_t(1281);
    check_val("a_red_t1281", red_a, 7);
    to_t(1282);
    check_val("a_red_x640", red_a, 0);
    check_val("a_blue_x640", blue_a, 0);
    to_t(1313);
    check_val("a_x656", xpos_a, 656);
    check_val("a_tick656", tick_a, 1);
    check_val("a_hs_pre", hs_a, 1);
    to_t(1314);
    check_val("a_hs_fall", hs_a, 0);
    to_t(1505);
    check_val("a_hs_last_low", hs_a, 0);
    to_t(1506);
    check_val("a_hs_rise", hs_a, 1);
    to_t(1599);
    check_val("a_x799", xpos_a, 799);
    check_val("a_y_line0", ypos_a, 0);
    to_t(1600);
    check_val("a_x_wrap", xpos_a, 0);
    check_val("a_y_line1", ypos_a, 1);
    check_val("a_fs_line", fs_a, 0);
    to_t(1602);
    check_val("a_red_line1", red_a, 7);
    to_t(2913);
    check_val("a_hs2_pre", hs_a, 1);
    to_t(2914);
    check_val("a_hs2_fall", hs_a, 0);
    to_t(3800);
    check_val("a_mid_x", xpos_a, 300);
    check_val("a_mid_y", ypos_a, 2);
    check_val("a_mid_red", red_a, 7);

    rst_a = 1'b1;
    @(negedge clk);
    check_val("a_rr_x", xpos_a, 0);
    check_val("a_rr_y", ypos_a, 0);
    check_val("a_rr_hs", hs_a, 1);
    check_val("a_rr_vs", vs_a, 1);
    check_val("a_rr_red", red_a, 0);
    check_val("a_rr_tick", tick_a, 0);
    rst_a = 1'b0;
    t = 0;
    #1;
    a_early_checks();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
